pass_lock_unit: RTL and testbench
=================================

# pass_lock_unit

Sequential, parametrised password checker for the smart-home access path. It holds a loadable system key and collects the user code one digit at a time. It compares the full code against the key and pulses grant or deny. After MAX_TRIES consecutive failures it locks out entry for a fixed number of cycles. Door and alarm control logic consume its `granted`, `denied` and `locked` outputs.

## Interface
- DIGIT_W, 4: bits per digit
- DIGITS, 4: digits per code; code width CODE_W = DIGITS*DIGIT_W
- MAX_TRIES, 3: consecutive failures before lockout (≥1)
- LOCK_CYCLES, 1000: lockout duration in clock cycles (≥1)
- TIMEOUT_CYCLES, 500: inter-digit timeout; used only with PASS_CHECK_TIMEOUT_EN
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- key_load  in  1  load `key_in` into key register
- key_in  in  CODE_W  new system key, digit 0 in MSBs
- digit_valid  in  1  `digit_in` valid this cycle
- digit_in  in  DIGIT_W  next user digit, first digit entered first
- clear  in  1  abandon the partial entry
- granted  out  1  one-cycle pulse: code matched
- denied  out  1  one-cycle pulse: code mismatched
- locked  out  1  high during lockout
- tries_left  out  $clog2(MAX_TRIES+1)  remaining attempts
- busy  out  1  high in states CHECK, GRANT, DENY and LOCKED
- timeout  out  1  one-cycle pulse; port present only with PASS_CHECK_TIMEOUT_EN

## Operation
- States: IDLE, ENTRY, CHECK, GRANT, DENY, LOCKED.
- Reset values:
  - state IDLE; key register, entry shift register and digit count all 0
  - tries_left = MAX_TRIES
  - granted, denied, locked, busy and timeout all 0
- IDLE:
  - `key_load` loads the key.
  - Otherwise, `digit_valid` shifts `digit_in` into the entry register and moves to ENTRY with count=1.
  - If `key_load` and `digit_valid` arrive together, `key_load` wins and the digit is dropped.
- ENTRY:
  - Each `digit_valid` shifts in one digit and increments count.
  - Accepting digit number DIGITS moves to CHECK. The count wraps to 0 at that point.
  - `key_load` is ignored.
- `clear` in IDLE or ENTRY empties the entry and count, returns to IDLE and consumes no try. If `clear` and `digit_valid` arrive together, `clear` wins.
- CHECK (one cycle) compares the full CODE_W entry against the key:
  - Equal: go to GRANT and set tries_left to MAX_TRIES.
  - Unequal: decrement tries_left. Go to LOCKED if the result is 0, otherwise go to DENY.
- GRANT and DENY last one cycle each, drive their pulse, then return to IDLE with the entry cleared.
- LOCKED:
  - `denied` pulses on the first cycle. `locked` is high for exactly LOCK_CYCLES cycles.
  - Then tries_left is set to MAX_TRIES and the state returns to IDLE.
- In CHECK, GRANT, DENY and LOCKED, `digit_valid`, `clear` and `key_load` are all ignored.
- `rst` asserted in any state, including mid-entry or mid-lockout, forces the reset values on the next edge.

## Timing
- All outputs are registered.
- If the last digit is sampled at edge t, CHECK is active in cycle t+1, and `granted` or `denied` is high in cycle t+2 for exactly one cycle.
- `locked` rises in the same cycle as the lockout `denied` pulse. It falls LOCK_CYCLES cycles later, and entry is accepted in the first cycle after that.
- tries_left updates in the cycle where `granted` or `denied` is high.
- A new digit can be accepted in the cycle after the grant or deny pulse.
- The key register updates one edge after `key_load`. A key loaded in IDLE applies to the next code.
- Lockout counter width is $clog2(LOCK_CYCLES+1). It decrements to 0 with no wrap.

## Configuration
- PASS_CHECK_TIMEOUT_EN defined:
  - In ENTRY, an idle counter counts cycles without `digit_valid` and reloads on every accepted digit.
  - After TIMEOUT_CYCLES idle cycles the entry is discarded, `timeout` pulses for one cycle and the state returns to IDLE.
  - No try is consumed.
  - If the timeout and `digit_valid` fall in the same cycle, the digit wins.
- PASS_CHECK_TIMEOUT_EN undefined: no idle counter and no `timeout` port; ENTRY waits indefinitely.

## Structure
- Package `pass_lock_pkg` holds the state enum and the tries_left and lockout-counter width functions.
- Sub-module `pass_lock_timer` is a loadable down-counter with a done flag. It is instantiated once for lockout and once more for the timeout when PASS_CHECK_TIMEOUT_EN is defined.

## Test plan
All scenarios use DIGIT_W=4, DIGITS=4, MAX_TRIES=3, LOCK_CYCLES=8, key 0x1234.
- Correct entry: digits 1,2,3,4 -> `granted` pulses 2 cycles after the last digit; tries_left=3; `denied` stays 0.
- Wrong code: 1,2,3,5 -> one `denied` pulse; tries_left=2.
- Three consecutive wrong codes:
  - The third `denied` pulse coincides with `locked` rising.
  - `locked` stays high for 8 cycles; digits during lockout are ignored.
  - tries_left returns to 3 afterwards.
- Interrupted entry: 1,2 then `clear`, then 1,2,3,4 -> `granted` pulses; tries_left unchanged at 3.
- Key change and same-cycle priority:
  - `key_load` 0xABCD in IDLE together with `digit_valid` -> the digit is dropped.
  - Then A,B,C,D -> `granted` pulses; 1,2,3,4 -> `denied` pulses.
- Reset and timeout:
  - `rst` during lockout -> next cycle `locked`=0, tries_left=3.
  - With PASS_CHECK_TIMEOUT_EN and TIMEOUT_CYCLES=5: digit 1, then 5 idle cycles -> `timeout` pulses; no `denied` pulse; tries_left=3.

Source files
------------

// File: rtl/pass_lock_pkg.sv
// Shared types and width helpers for the pass_lock_unit block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pass_lock_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTRY,
    S_CHECK,
    S_GRANT,
    S_DENY,
    S_LOCKED
  } state_t;

  // Width of the tries_left counter: must hold 0..max_tries.
  function automatic int tries_width(input int max_tries);
    return $clog2(max_tries + 1);
  endfunction

  // Width of the lockout counter: must hold 0..lock_cycles.
  function automatic int lock_width(input int lock_cycles);
    return $clog2(lock_cycles + 1);
  endfunction

  // Digit position counter; at least one bit even for single-digit codes.
  function automatic int count_width(input int digits);
    return (digits > 1) ? $clog2(digits) : 1;
  endfunction

endpackage

// File: rtl/pass_lock_unit_if.sv
// Handshake/bus bundle between the access controller and pass_lock_unit.
// Latency: n/a (wiring only).
// Backpressure: none; digits are offered with digit_valid and dropped when the unit is busy.
// Ports: master drives key_load/key_in/digit_valid/digit_in/clear and observes
//        granted/denied/locked/tries_left/busy (+timeout with PASS_CHECK_TIMEOUT_EN);
//        slave is the pass_lock_unit side.
interface pass_lock_unit_if
  import pass_lock_pkg::*;
#(
  parameter int DIGIT_W   = 4,
  parameter int DIGITS    = 4,
  parameter int MAX_TRIES = 3
);
  localparam int CODE_W = DIGIT_W * DIGITS;
  localparam int TW     = tries_width(MAX_TRIES);

  logic              key_load;
  logic [CODE_W-1:0] key_in;
  logic              digit_valid;
  logic [DIGIT_W-1:0] digit_in;
  logic              clear;
  logic              granted;
  logic              denied;
  logic              locked;
  logic [TW-1:0]     tries_left;
  logic              busy;
`ifdef PASS_CHECK_TIMEOUT_EN
  logic              timeout;
`endif

  modport master (
    output key_load, key_in, digit_valid, digit_in, clear,
    input  granted, denied, locked, tries_left, busy
`ifdef PASS_CHECK_TIMEOUT_EN
    , input timeout
`endif
  );

  modport slave (
    input  key_load, key_in, digit_valid, digit_in, clear,
    output granted, denied, locked, tries_left, busy
`ifdef PASS_CHECK_TIMEOUT_EN
    , output timeout
`endif
  );

endinterface

// File: rtl/pass_lock_timer.sv
// Loadable down-counter with a done flag; stops at zero without wrapping.
// Latency: load_val visible one edge after load; done is combinational from the count.
// Backpressure: none.
// Ports: clk, rst (sync, active-high), load/load_val, en (decrement), done (count == 0).
module pass_lock_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/pass_lock_unit.sv
// Sequential password checker: collects DIGITS digits, compares with the key, pulses grant/deny, locks out after MAX_TRIES failures.
// Latency: granted/denied appear two cycles after the last digit is sampled; all outputs registered.
// Backpressure: none; digits, clear and key_load offered while busy are silently dropped.
// Ports: clk, rst (sync, active-high), bus (pass_lock_unit_if.slave).
// Optional: PASS_CHECK_TIMEOUT_EN adds an inter-digit idle timeout and the timeout pulse.
module pass_lock_unit
  import pass_lock_pkg::*;
#(
  parameter int DIGIT_W     = 4,
  parameter int DIGITS      = 4,
  parameter int MAX_TRIES   = 3,
  parameter int LOCK_CYCLES = 1000
`ifdef PASS_CHECK_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 500
`endif
) (
  input logic clk,
  input logic rst,
  pass_lock_unit_if.slave bus
);

  localparam int CODE_W = DIGIT_W * DIGITS;
  localparam int TW     = tries_width(MAX_TRIES);
  localparam int LW     = lock_width(LOCK_CYCLES);
  localparam int CW     = count_width(DIGITS);

  state_t            state;
  logic [CODE_W-1:0] key_r;
  logic [CODE_W-1:0] entry_r;
  logic [CW-1:0]     cnt;
  logic [TW-1:0]     tries_r;
  logic              granted_r;
  logic              denied_r;
  logic              locked_r;
  logic              busy_r;

  logic can_enter;
  logic take_digit;
  logic last_digit;
  logic code_match;
  logic lock_start;
  logic lock_done;

  assign can_enter  = (state == S_IDLE) || (state == S_ENTRY);
  // clear beats a digit everywhere; key_load beats a digit only in IDLE.
  assign take_digit = can_enter && bus.digit_valid && !bus.clear &&
                      !((state == S_IDLE) && bus.key_load);
  assign last_digit = (cnt == CW'(DIGITS - 1));
  assign code_match = (entry_r == key_r);
  assign lock_start = (state == S_CHECK) && !code_match && (tries_r == TW'(1));

  // Loaded with LOCK_CYCLES-1 on entry to LOCKED so the exit edge lands
  // exactly LOCK_CYCLES cycles after locked rises.
  pass_lock_timer #(.W(LW)) u_lock_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (lock_start),
    .load_val (LW'(LOCK_CYCLES - 1)),
    .en       (state == S_LOCKED),
    .done     (lock_done)
  );

`ifdef PASS_CHECK_TIMEOUT_EN
  localparam int IW = lock_width(TIMEOUT_CYCLES);
  logic idle_done;
  logic timeout_r;

  // Reloaded on every accepted digit; expires after TIMEOUT_CYCLES idle ENTRY cycles.
  pass_lock_timer #(.W(IW)) u_idle_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (take_digit),
    .load_val (IW'(TIMEOUT_CYCLES - 1)),
    .en       (state == S_ENTRY),
    .done     (idle_done)
  );

  assign bus.timeout = timeout_r;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      key_r     <= '0;
      entry_r   <= '0;
      cnt       <= '0;
      tries_r   <= TW'(MAX_TRIES);
      granted_r <= 1'b0;
      denied_r  <= 1'b0;
      locked_r  <= 1'b0;
      busy_r    <= 1'b0;
`ifdef PASS_CHECK_TIMEOUT_EN
      timeout_r <= 1'b0;
`endif
    end else begin
      granted_r <= 1'b0;
      denied_r  <= 1'b0;
`ifdef PASS_CHECK_TIMEOUT_EN
      timeout_r <= 1'b0;
`endif
      case (state)
        S_IDLE, S_ENTRY: begin
          if ((state == S_IDLE) && bus.key_load) begin
            key_r <= bus.key_in;
          end
          if (bus.clear) begin
            entry_r <= '0;
            cnt     <= '0;
            state   <= S_IDLE;
          end else if (take_digit) begin
            // First digit ends up in the MSBs after DIGITS shifts.
            entry_r <= (entry_r << DIGIT_W) | CODE_W'(bus.digit_in);
            if (last_digit) begin
              cnt    <= '0;
              state  <= S_CHECK;
              busy_r <= 1'b1;
            end else begin
              cnt   <= cnt + CW'(1);
              state <= S_ENTRY;
            end
          end
`ifdef PASS_CHECK_TIMEOUT_EN
          else if ((state == S_ENTRY) && idle_done) begin
            entry_r   <= '0;
            cnt       <= '0;
            state     <= S_IDLE;
            timeout_r <= 1'b1;
          end
`endif
        end
        S_CHECK: begin
          entry_r <= '0;
          if (code_match) begin
            state     <= S_GRANT;
            granted_r <= 1'b1;
            tries_r   <= TW'(MAX_TRIES);
          end else if (tries_r == TW'(1)) begin
            state    <= S_LOCKED;
            denied_r <= 1'b1;
            locked_r <= 1'b1;
            tries_r  <= '0;
          end else begin
            state    <= S_DENY;
            denied_r <= 1'b1;
            tries_r  <= tries_r - TW'(1);
          end
        end
        S_GRANT, S_DENY: begin
          state  <= S_IDLE;
          busy_r <= 1'b0;
        end
        S_LOCKED: begin
          if (lock_done) begin
            state    <= S_IDLE;
            locked_r <= 1'b0;
            busy_r   <= 1'b0;
            tries_r  <= TW'(MAX_TRIES);
          end
        end
        default: begin
          state  <= S_IDLE;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.granted    = granted_r;
  assign bus.denied     = denied_r;
  assign bus.locked     = locked_r;
  assign bus.tries_left = tries_r;
  assign bus.busy       = busy_r;

endmodule

// File: tb/tb_pass_lock_unit.sv
// Randomized + directed bench for pass_lock_unit with a timeline-level reference model.
// Latency: n/a.  Backpressure: n/a.
module tb_pass_lock_unit;

  localparam int DIGIT_W = 4;
  localparam int DIGITS  = 4;
  localparam int MAXT    = 3;
  localparam int LOCKC   = 8;
  localparam int TOC     = 5;
  localparam int CODE_W  = DIGIT_W * DIGITS;

  typedef struct { int idx; int val; } sch_t;
  typedef struct { int idx; int kind; } ev_t;   // kind: 0 grant, 1 deny, 2 deny+lock, 3 timeout

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   edge_no = 0;
  bit   mon_en = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  pass_lock_unit_if #(.DIGIT_W(DIGIT_W), .DIGITS(DIGITS), .MAX_TRIES(MAXT)) bus ();

  pass_lock_unit #(
    .DIGIT_W(DIGIT_W), .DIGITS(DIGITS), .MAX_TRIES(MAXT), .LOCK_CYCLES(LOCKC)
`ifdef PASS_CHECK_TIMEOUT_EN
    , .TIMEOUT_CYCLES(TOC)
`endif
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic to_o;
`ifdef PASS_CHECK_TIMEOUT_EN
  assign to_o = bus.timeout;
`else
  assign to_o = 1'b0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) edge_no <= edge_no + 1;

  // Reference model: what the user has typed, when input is accepted again,
  // and queues of expected output changes indexed by the edge after which they show.
  int   key_m = 0;
  int   entry_m[$];
  int   tries_m = MAXT;
  int   acc_from = 0;
  int   last_acc = 0;
  sch_t tq[$];
  sch_t lq[$];
  sch_t bq[$];
  ev_t  evq[$];

  task automatic flush_from(input int n);
    sch_t ks[$];
    ev_t  ke[$];
    ks.delete(); foreach (tq[i]) if (tq[i].idx < n) ks.push_back(tq[i]); tq = ks;
    ks.delete(); foreach (lq[i]) if (lq[i].idx < n) ks.push_back(lq[i]); lq = ks;
    ks.delete(); foreach (bq[i]) if (bq[i].idx < n) ks.push_back(bq[i]); bq = ks;
    ke.delete(); foreach (evq[i]) if (evq[i].idx < n) ke.push_back(evq[i]); evq = ke;
  endtask

  task automatic model_edge(input int n, input bit r, input bit kl, input int kin,
                            input bit dv, input int d, input bit clr);
    int code;
    if (r) begin
      flush_from(n);
      tq.push_back(sch_t'{n, MAXT});
      lq.push_back(sch_t'{n, 0});
      bq.push_back(sch_t'{n, 0});
      key_m = 0; entry_m.delete(); tries_m = MAXT; acc_from = n + 1;
      return;
    end
    if (n < acc_from) return;
    if (entry_m.size() == 0 && kl) key_m = kin;
    if (clr) begin
      entry_m.delete();
    end else if (kl && entry_m.size() == 0) begin
      // digit dropped in favour of the key load
    end else if (dv) begin
      entry_m.push_back(d);
      last_acc = n;
      if (entry_m.size() == DIGITS) begin
        code = 0;
        foreach (entry_m[i]) code = code * (1 << DIGIT_W) + entry_m[i];
        entry_m.delete();
        bq.push_back(sch_t'{n, 1});
        if (code == key_m) begin
          tries_m = MAXT;
          evq.push_back(ev_t'{n + 1, 0});
          tq.push_back(sch_t'{n + 1, MAXT});
          bq.push_back(sch_t'{n + 2, 0});
          acc_from = n + 3;
        end else begin
          tries_m = tries_m - 1;
          if (tries_m == 0) begin
            evq.push_back(ev_t'{n + 1, 2});
            tq.push_back(sch_t'{n + 1, 0});
            lq.push_back(sch_t'{n + 1, 1});
            lq.push_back(sch_t'{n + 1 + LOCKC, 0});
            tq.push_back(sch_t'{n + 1 + LOCKC, MAXT});
            bq.push_back(sch_t'{n + 1 + LOCKC, 0});
            tries_m = MAXT;
            acc_from = n + LOCKC + 2;
          end else begin
            evq.push_back(ev_t'{n + 1, 1});
            tq.push_back(sch_t'{n + 1, tries_m});
            bq.push_back(sch_t'{n + 2, 0});
            acc_from = n + 3;
          end
        end
      end
    end
`ifdef PASS_CHECK_TIMEOUT_EN
    else if (entry_m.size() > 0 && (n - last_acc) == TOC) begin
      evq.push_back(ev_t'{n, 3});
      entry_m.delete();
    end
`endif
  endtask

  task automatic step(input bit r, input bit kl, input int kin,
                      input bit dv, input int d, input bit clr);
    int n;
    @(negedge clk);
    rst             = r;
    bus.key_load    = kl;
    bus.key_in      = kin[CODE_W-1:0];
    bus.digit_valid = dv;
    bus.digit_in    = d[DIGIT_W-1:0];
    bus.clear       = clr;
    n = edge_no + 1;
    model_edge(n, r, kl, kin, dv, d, clr);
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic enter_code(input int code);
    for (int i = DIGITS - 1; i >= 0; i--) step(0, 0, 0, 1, (code >> (DIGIT_W * i)) & 15, 0);
  endtask

  task automatic check(input string name, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", name, edge_no, got, want);
    end
  endtask

  // Monitor: applies scheduled expectations and checks every sampled cycle.
  int  exp_t = MAXT;
  int  exp_l = 0;
  int  exp_b = 0;
  always @(negedge clk) begin : mon
    ev_t e;
    int  k;
    if (mon_en) begin
      k = edge_no;
      while (tq.size() > 0 && tq[0].idx <= k) exp_t = tq.pop_front().val;
      while (lq.size() > 0 && lq[0].idx <= k) exp_l = lq.pop_front().val;
      while (bq.size() > 0 && bq[0].idx <= k) exp_b = bq.pop_front().val;
      check("tries_left", int'(bus.tries_left), exp_t);
      check("locked", int'(bus.locked), exp_l);
      check("busy", int'(bus.busy), exp_b);
      while (evq.size() > 0 && evq[0].idx < k) begin
        e = evq.pop_front();
        check("missed_pulse_kind", -1, e.kind);
      end
      if (bus.granted || bus.denied || to_o) begin
        if (evq.size() > 0 && evq[0].idx == k) begin
          e = evq.pop_front();
          check("granted", int'(bus.granted), int'(e.kind == 0));
          check("denied", int'(bus.denied), int'(e.kind == 1 || e.kind == 2));
          check("timeout", int'(to_o), int'(e.kind == 3));
        end else begin
          check("unexpected_pulse", {29'd0, bus.granted, bus.denied, to_o}, 0);
        end
      end else if (evq.size() > 0 && evq[0].idx == k) begin
        e = evq.pop_front();
        check("missing_pulse_kind", -1, e.kind);
      end
    end
  end

  initial begin
    int pos;
    int kd;
    bus.key_load = 1'b0; bus.key_in = '0; bus.digit_valid = 1'b0;
    bus.digit_in = '0; bus.clear = 1'b0;

    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    mon_en = 1'b1;
    idle(2);
    check("reset_granted", int'(bus.granted), 0);
    check("reset_denied", int'(bus.denied), 0);

    // Key load, correct code, wrong code.
    step(0, 1, 'h1234, 0, 0, 0); idle(2);
    enter_code('h1234); idle(3);
    enter_code('h1235); idle(3);
    enter_code('h1234); idle(3);
    // Three wrong codes into lockout; digits during lockout are ignored.
    enter_code('h1111); idle(3);
    enter_code('h1111); idle(3);
    enter_code('h1111);
    for (int i = 0; i < LOCKC + 2; i++) step(0, 0, 0, 1, 1, 0);
    idle(3);
    // Interrupted entry.
    step(0, 0, 0, 1, 1, 0); step(0, 0, 0, 1, 2, 0); step(0, 0, 0, 0, 0, 1);
    enter_code('h1234); idle(3);
    // Key change with same-cycle digit (dropped).
    step(0, 1, 'hABCD, 1, 'hA, 0);
    enter_code('hABCD); idle(3);
    enter_code('h1234); idle(3);
    step(0, 1, 'h1234, 0, 0, 0); idle(2);
    // Reset during lockout.
    enter_code('h2222); idle(3);
    enter_code('h2222); idle(3);
    enter_code('h2222); idle(4);
    step(1, 0, 0, 0, 0, 0);
    idle(3);
    step(0, 1, 'h1234, 0, 0, 0); idle(2);
`ifdef PASS_CHECK_TIMEOUT_EN
    step(0, 0, 0, 1, 1, 0); idle(TOC + 2);
    enter_code('h1234); idle(3);
`endif

    // Random traffic biased toward the current key so grants, denies and lockouts all occur.
    for (int i = 0; i < 1500; i++) begin
      pos = entry_m.size() % DIGITS;
      kd  = (key_m >> (DIGIT_W * (DIGITS - 1 - pos))) & 15;
      step(($urandom % 300) == 0,
           ($urandom % 50) == 0,
           (($urandom % 2) == 0) ? 'h1234 : int'($urandom % 65536),
           ($urandom % 4) != 0,
           (($urandom % 5) != 0) ? kd : int'($urandom % 16),
           ($urandom % 40) == 0);
      if (($urandom % 30) == 0) idle(TOC + 1);
    end
    idle(LOCKC + 10);
    check("pending_events", evq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
